// File: rtl/sync_pkg.sv
// Shared defaults and sizing helpers for the input synchroniser bank.
// Latency: n/a (constants and an elaboration-time function only).
// Backpressure: n/a.
package sync_pkg;

    localparam int SYNC_STAGES_DEFAULT   = 2;
    localparam int SYNC_DEBOUNCE_DEFAULT = 1;

    // Counter width that can hold DEBOUNCE-1, never narrower than one bit.
    function automatic int cnt_width(input int debounce);
        int w;
        w = $clog2(debounce + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_cell.sv
// One channel: synchroniser chain, stability filter, registered rise/fall pulses.
// Latency: STAGES+DEBOUNCE edges from a stable din change to dout/rise/fall.
// Backpressure: none; level input sampled every cycle, pulses are fire-and-forget.
module sync_debounce_cell
    import sync_pkg::*;
#(
    parameter int   STAGES    = SYNC_STAGES_DEFAULT,
    parameter int   DEBOUNCE  = SYNC_DEBOUNCE_DEFAULT,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic pre_pulse
);

    localparam int            CW       = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "sync_debounce_cell: STAGES must be in 2..4");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $fatal(1, "sync_debounce_cell: DEBOUNCE must be >= 1");
    end

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] chain;

    logic          synced;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign synced = chain[STAGES-1];
    assign accept = (synced != level) && (cnt == CNT_LAST);

    // Any agreement with the current level throws away the partial count.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= RESET_VAL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= accept & synced;
            fall <= accept & ~synced;
            if (synced == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout      = level;
    assign pre_pulse = accept;

endmodule

// File: rtl/sync_input_bank.sv
// WIDTH independent async level inputs synchronised and debounced into clk.
// Latency: STAGES+DEBOUNCE edges per channel; any_change aligned with rise/fall.
// Backpressure: none; outputs are levels and single-cycle events.
module sync_input_bank
    import sync_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = SYNC_STAGES_DEFAULT,
    parameter int               DEBOUNCE  = SYNC_DEBOUNCE_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    logic [WIDTH-1:0] pre_pulse;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        (* keep_hierarchy = "yes" *)
        sync_debounce_cell #(
            .STAGES   (STAGES),
            .DEBOUNCE (DEBOUNCE),
            .RESET_VAL(RESET_VAL[i])
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .din      (din[i]),
            .dout     (dout[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .pre_pulse(pre_pulse[i])
        );
    end

    // Registered from the cells' pre-pulses so it lands with rise/fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |pre_pulse;
        end
    end

endmodule

// File: tb/tb_sync_input_bank.sv
// Three bank configurations driven with directed and random stimulus, checked
// every cycle against a window-based behavioural model plus pinned literal points.
module tb_sync_input_bank;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] din_a, din_b;
    logic [0:0] din_c;
    logic [3:0] dout_a, rise_a, fall_a, dout_b, rise_b, fall_b;
    logic [0:0] dout_c, rise_c, fall_c;
    logic any_a, any_b, any_c;

    always #5 clk = ~clk;

    sync_input_bank #(.WIDTH(4), .STAGES(2), .DEBOUNCE(4), .RESET_VAL(4'h0)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .dout(dout_a),
        .rise(rise_a), .fall(fall_a), .any_change(any_a));
    sync_input_bank #(.WIDTH(4), .STAGES(2), .DEBOUNCE(4), .RESET_VAL(4'hF)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .dout(dout_b),
        .rise(rise_b), .fall(fall_b), .any_change(any_b));
    sync_input_bank #(.WIDTH(1), .STAGES(3), .DEBOUNCE(1), .RESET_VAL(1'b0)) dut_c (
        .clk(clk), .reset(reset), .din(din_c), .dout(dout_c),
        .rise(rise_c), .fall(fall_c), .any_change(any_c));

    localparam int       W_ [3] = '{4, 4, 1};
    localparam int       S_ [3] = '{2, 2, 3};
    localparam int       D_ [3] = '{4, 4, 1};
    localparam bit [3:0] RV_[3] = '{4'h0, 4'hF, 4'h0};
    localparam int       HIST   = 2048;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Value captured into each chain at each edge, and model state.
    bit sv      [3][4][HIST];
    bit mlevel  [3][4];
    int last_ev [3][4];
    bit mrise   [3][4];
    bit mfall   [3][4];
    bit many    [3];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic bit synced_at(input int i, input int c, input int k);
        int idx;
        idx = k - S_[i];
        if (idx < 1) return RV_[i][c];
        return sv[i][c][idx];
    endfunction

    // A channel flips at edge k when the DEBOUNCE synced samples at edges
    // k-D+1..k all disagree with its level and no reset or flip lies inside that window.
    always @(posedge clk) begin
        logic [3:0] dv;
        bit ok;
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            dv = (i == 0) ? din_a : (i == 1) ? din_b : {3'b000, din_c};
            many[i] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                mrise[i][c] = 1'b0;
                mfall[i][c] = 1'b0;
                if (c < W_[i]) begin
                    sv[i][c][cyc % HIST] = reset ? RV_[i][c] : dv[c];
                    if (reset) begin
                        mlevel[i][c]  = RV_[i][c];
                        last_ev[i][c] = cyc;
                    end else if (cyc - D_[i] >= last_ev[i][c]) begin
                        ok = 1'b1;
                        for (int j = 0; j < D_[i]; j++)
                            if (synced_at(i, c, cyc - j) == mlevel[i][c]) ok = 1'b0;
                        if (ok) begin
                            mlevel[i][c]  = ~mlevel[i][c];
                            last_ev[i][c] = cyc;
                            mrise[i][c]   = mlevel[i][c];
                            mfall[i][c]   = ~mlevel[i][c];
                        end
                    end
                    many[i] = many[i] | mrise[i][c] | mfall[i][c];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] el, er, ef, gl, gr, gf;
        logic ga;
        if (cyc >= 1) begin
            for (int i = 0; i < 3; i++) begin
                el = '0; er = '0; ef = '0;
                for (int c = 0; c < W_[i]; c++) begin
                    el[c] = mlevel[i][c];
                    er[c] = mrise[i][c];
                    ef[c] = mfall[i][c];
                end
                case (i)
                    0: begin gl = dout_a; gr = rise_a; gf = fall_a; ga = any_a; end
                    1: begin gl = dout_b; gr = rise_b; gf = fall_b; ga = any_b; end
                    default: begin
                        gl = {3'b000, dout_c}; gr = {3'b000, rise_c};
                        gf = {3'b000, fall_c}; ga = any_c;
                    end
                endcase
                chk($sformatf("model_dout%0d", i), gl, el);
                chk($sformatf("model_rise%0d", i), gr, er);
                chk($sformatf("model_fall%0d", i), gf, ef);
                chk($sformatf("model_any%0d", i), {3'b000, ga}, {3'b000, many[i]});
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e, r, hold_c;
        reset = 1'b1;
        din_a = '0; din_b = '0; din_c = '0;
        wait_to(3);
        reset = 1'b0;
        r = cyc;
        wait_to(r);
        chk("b_reset_dout", dout_b, 4'hF);
        chk("b_reset_fall", fall_b, 4'h0);
        wait_to(r + 5);
        chk("b_pre_fall", fall_b, 4'h0);
        chk("b_pre_dout", dout_b, 4'hF);
        wait_to(r + 6);
        chk("b_fall_all", fall_b, 4'hF);
        chk("b_any", {3'b000, any_b}, 4'h1);
        chk("b_dout_low", dout_b, 4'h0);
        wait_to(r + 10);

        e = cyc; din_a[0] = 1'b1;
        wait_to(e + 5);
        chk("a0_rise_early", rise_a, 4'h0);
        chk("a0_dout_early", dout_a, 4'h0);
        wait_to(e + 6);
        chk("a0_rise", rise_a, 4'h1);
        chk("a0_any", {3'b000, any_a}, 4'h1);
        chk("a0_dout", dout_a, 4'h1);
        wait_to(e + 7);
        chk("a0_rise_once", rise_a, 4'h0);
        chk("a0_any_once", {3'b000, any_a}, 4'h0);
        wait_to(e + 12);

        e = cyc; din_a[1] = 1'b1;
        wait_to(e + 3); din_a[1] = 1'b0;
        wait_to(e + 12);
        chk("a1_glitch_dout", dout_a, 4'h1);
        e = cyc; din_a[1] = 1'b1;
        wait_to(e + 4); din_a[1] = 1'b0;
        wait_to(e + 6);
        chk("a1_rise", rise_a, 4'h2);
        wait_to(e + 9);
        chk("a1_fall_early", fall_a, 4'h0);
        wait_to(e + 10);
        chk("a1_fall", fall_a, 4'h2);
        wait_to(e + 14);

        din_a = 4'h0;
        wait_to(cyc + 12);
        e = cyc; din_a = 4'b1010;
        wait_to(e + 6);
        chk("a_multi_rise", rise_a, 4'b1010);
        chk("a_multi_any", {3'b000, any_a}, 4'h1);
        chk("a_multi_dout", dout_a, 4'b1010);
        wait_to(e + 7);
        chk("a_multi_any_once", {3'b000, any_a}, 4'h0);
        wait_to(e + 10);

        din_a = 4'h0;
        wait_to(cyc + 12);
        e = cyc; din_a = 4'b0001;
        wait_to(e + 4); reset = 1'b1;
        wait_to(e + 5); reset = 1'b0;
        r = cyc;
        chk("rst_mid_dout", dout_a, 4'h0);
        chk("rst_mid_rise", rise_a, 4'h0);
        chk("rst_b_nopulse", fall_b, 4'h0);
        wait_to(r + 5);
        chk("rst_rel_rise_early", rise_a, 4'h0);
        wait_to(r + 6);
        chk("rst_rel_rise", rise_a, 4'h1);
        chk("rst_rel_dout", dout_a, 4'h1);
        wait_to(r + 10);

        hold_c = 2;
        for (int n = 0; n < 700; n++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) din_a = 4'($urandom);
            if ($urandom_range(0, 5) == 0) din_b = 4'($urandom);
            hold_c--;
            if (hold_c <= 0) begin
                #($urandom_range(0, 7));
                din_c  = ~din_c;
                hold_c = $urandom_range(2, 6);
            end
        end
        wait_to(cyc + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
